// File: rtl/soc_network_adapter_config_arbiter_if.sv
// Requester and configuration-register-file bus shared by the config arbiter.
// The master side is the requester/register-file environment, the slave side is the arbiter.
interface soc_network_adapter_config_arbiter_if #(
    parameter int unsigned DW   = 32,
    parameter int unsigned NREQ = 2
);
    logic [NREQ-1:0]    req;
    logic [NREQ*16-1:0] req_addr;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*DW-1:0] req_din;
    logic [NREQ-1:0]    ack;
    logic [NREQ-1:0]    err;
    logic [DW-1:0]      dout;
    logic               busy;
    logic [15:0]        cfg_addr;
    logic [DW-1:0]      cfg_din;
    logic               cfg_en;
    logic               cfg_we;
    logic [DW-1:0]      cfg_dout;

    modport master (
        output req, req_addr, req_we, req_din, cfg_dout,
        input  ack, err, dout, busy, cfg_addr, cfg_din, cfg_en, cfg_we
    );

    modport slave (
        input  req, req_addr, req_we, req_din, cfg_dout,
        output ack, err, dout, busy, cfg_addr, cfg_din, cfg_en, cfg_we
    );
endinterface

// File: rtl/soc_network_adapter_config_arbiter.sv
// Round-robin arbiter granting NREQ requesters one at a time onto a configuration register file,
// with address decode that turns illegal accesses into err completions.
module soc_network_adapter_config_arbiter #(
    parameter int unsigned DW   = 32,
    parameter int unsigned NREQ = 2
) (
    input logic clk,
    input logic rst,
    soc_network_adapter_config_arbiter_if.slave bus
);
    localparam int unsigned IW = $clog2(NREQ);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e          r_state;
    logic [IW-1:0]   r_last;
    logic [IW-1:0]   r_gnt;
    logic            r_we;
    logic            r_ok;
    logic [NREQ-1:0] r_ack;
    logic [NREQ-1:0] r_err;
    logic [DW-1:0]   r_dout;
    logic [15:0]     r_cfg_addr;
    logic [DW-1:0]   r_cfg_din;
    logic            r_cfg_en;
    logic            r_cfg_we;
    logic            r_busy;

    logic            w_any;
    logic            w_found;
    logic [IW-1:0]   w_win;
    logic [15:0]     w_addr;
    logic [DW-1:0]   w_din;
    logic            w_we;
    logic            w_word_ok;
    logic            w_rd_ok;
    logic            w_ok;

    assign w_any = |bus.req;

    // Search starts one past the last winner and wraps.
    always_comb begin : rr_search
        int unsigned   sum;
        logic [IW-1:0] cand;
        w_win   = r_last;
        w_found = 1'b0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            sum = 32'(r_last) + i;
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            cand = sum[IW-1:0];
            if (!w_found && bus.req[cand]) begin
                w_found = 1'b1;
                w_win   = cand;
            end
        end
    end

    always_comb begin
        w_addr = '0;
        w_din  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (w_win == IW'(k)) begin
                w_addr = bus.req_addr[k*16 +: 16];
                w_din  = bus.req_din[k*DW +: DW];
            end
        end
    end

    assign w_we = bus.req_we[w_win];

    always_comb begin
        case (w_addr[11:2])
            10'h000, 10'h001, 10'h003, 10'h004, 10'h006, 10'h007, 10'h008,
            10'h009, 10'h00A, 10'h00B, 10'h040, 10'h041, 10'h042: w_word_ok = 1'b1;
            default:                                               w_word_ok = 1'b0;
        endcase
    end

    // Halfword region 0x200-0x3FF allows addr[1]=1; the word list does not.
    assign w_rd_ok = (w_addr[15:12] == 4'h0) && !w_addr[0] &&
                     ((!w_addr[1] && w_word_ok) || (w_addr[11:9] == 3'b001));
    assign w_ok    = w_we ? (w_addr == 16'h0108) : w_rd_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_last     <= IW'(NREQ - 1);
            r_gnt      <= '0;
            r_we       <= 1'b0;
            r_ok       <= 1'b0;
            r_ack      <= '0;
            r_err      <= '0;
            r_dout     <= '0;
            r_cfg_addr <= '0;
            r_cfg_din  <= '0;
            r_cfg_en   <= 1'b0;
            r_cfg_we   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_ack <= '0;
                    r_err <= '0;
                    if (w_any) begin
                        r_state    <= StAccess;
                        r_busy     <= 1'b1;
                        r_gnt      <= w_win;
                        r_last     <= w_win;
                        r_we       <= w_we;
                        r_ok       <= w_ok;
                        r_cfg_addr <= w_addr;
                        r_cfg_din  <= w_din;
                        r_cfg_en   <= w_ok;
                        r_cfg_we   <= w_ok & w_we;
                    end
                end
                StAccess: begin
                    r_state  <= StResp;
                    r_cfg_en <= 1'b0;
                    r_cfg_we <= 1'b0;
                    r_dout   <= (r_ok && !r_we) ? bus.cfg_dout : '0;
                end
                StResp: begin
                    r_state      <= StIdle;
                    r_busy       <= 1'b0;
                    r_ack[r_gnt] <= r_ok;
                    r_err[r_gnt] <= !r_ok;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.ack      = r_ack;
    assign bus.err      = r_err;
    assign bus.dout     = r_dout;
    assign bus.busy     = r_busy;
    assign bus.cfg_addr = r_cfg_addr;
    assign bus.cfg_din  = r_cfg_din;
    assign bus.cfg_en   = r_cfg_en;
    assign bus.cfg_we   = r_cfg_we;
endmodule

// File: tb/tb_soc_network_adapter_config_arbiter.sv
// Bench for the config arbiter: directed scenarios then randomized requesters, all checked
// against a transaction-level model of grant order, timing, decode and register-file data.
`timescale 1ns/1ps
module tb_soc_network_adapter_config_arbiter;
    localparam int unsigned DW   = 32;
    localparam int unsigned NREQ = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    soc_network_adapter_config_arbiter_if #(.DW(DW), .NREQ(NREQ)) bus ();

    soc_network_adapter_config_arbiter #(.DW(DW), .NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned rd_words [13] = '{0, 1, 3, 4, 6, 7, 8, 9, 10, 11, 64, 65, 66};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit auto_mode = 1'b0;
    bit waiting [NREQ];

    // Transaction-level model state.
    bit            m_active;
    int            m_gcyc;
    int            m_g;
    int            m_last;
    logic [15:0]   m_addr;
    bit            m_we;
    logic [DW-1:0] m_din;
    bit            m_ok;
    logic [DW-1:0] m_rdata;
    logic [15:0]   m_cfg_addr;
    logic [DW-1:0] m_cfg_din;

    function automatic logic [DW-1:0] rf_value(logic [15:0] a);
        return {~a, a} ^ 32'h5A5A_C3C3;
    endfunction

    assign bus.cfg_dout = rf_value(bus.cfg_addr);

    function automatic bit legal(bit we, logic [15:0] a);
        int unsigned w;
        if (we) return a == 16'h0108;
        if (a >= 16'h1000 || (a % 2) != 0) return 1'b0;
        if (a >= 16'h0200 && a < 16'h0400) return 1'b1;
        if ((a % 4) != 0) return 1'b0;
        w = a / 4;
        foreach (rd_words[i]) if (rd_words[i] == w) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] gen_addr();
        logic [15:0] a;
        case ($urandom_range(0, 7))
            0:       a = 16'(rd_words[$urandom_range(0, 12)] * 4);
            1:       a = 16'h0200 + 16'($urandom_range(0, 255) * 2);
            2:       a = 16'h0108;
            3:       a = 16'($urandom);
            4:       a = 16'(rd_words[$urandom_range(0, 12)] * 4 + 2);
            5:       a = 16'($urandom) | 16'h0001;
            6:       a = ($urandom_range(0, 1) != 0) ? 16'h0008 : 16'h0014;
            default: a = 16'h0004 | 16'($urandom_range(1, 15) << 12);
        endcase
        return a;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic issue(input int k, input logic [15:0] a, input bit we, input logic [DW-1:0] d);
        waiting[k]                = 1'b1;
        bus.req[k]                = 1'b1;
        bus.req_addr[k*16 +: 16]  = a;
        bus.req_we[k]             = we;
        bus.req_din[k*DW +: DW]   = d;
    endtask

    task automatic model_reset();
        m_active   = 1'b0;
        m_last     = NREQ - 1;
        m_cfg_addr = '0;
        m_cfg_din  = '0;
        m_rdata    = '0;
    endtask

    task automatic check_reset_outputs();
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_cfg_en", bus.cfg_en, 0);
        check_val("rst_cfg_we", bus.cfg_we, 0);
        check_val("rst_ack", bus.ack, 0);
        check_val("rst_err", bus.err, 0);
        check_val("rst_dout", bus.dout, 0);
        check_val("rst_cfg_addr", bus.cfg_addr, 0);
        check_val("rst_cfg_din", bus.cfg_din, 0);
    endtask

    // Asserted mid-cycle so the asynchronous clear is observed before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        for (int k = 0; k < NREQ; k++) if (waiting[k]) bus.req[k] = 1'b1;
    endtask

    task automatic model_and_check();
        logic [NREQ-1:0] r;
        logic [NREQ-1:0] e_ack;
        logic [NREQ-1:0] e_err;
        bit              e_busy;
        bit              e_en;
        bit              e_we;
        int              off;
        int              pick;
        r      = bus.req;
        e_ack  = '0;
        e_err  = '0;
        e_busy = 1'b0;
        e_en   = 1'b0;
        e_we   = 1'b0;
        if (m_active && (cyc - m_gcyc) >= 3) m_active = 1'b0;
        if (!m_active && r != '0) begin
            pick = -1;
            for (int i = 1; i <= NREQ; i++) begin
                int k;
                k = (m_last + i) % NREQ;
                if (pick < 0 && r[k]) pick = k;
            end
            m_active   = 1'b1;
            m_gcyc     = cyc;
            m_g        = pick;
            m_last     = pick;
            m_addr     = bus.req_addr[pick*16 +: 16];
            m_we       = bus.req_we[pick];
            m_din      = bus.req_din[pick*DW +: DW];
            m_ok       = legal(m_we, m_addr);
            m_rdata    = (m_ok && !m_we) ? rf_value(m_addr) : '0;
            m_cfg_addr = m_addr;
            m_cfg_din  = m_din;
        end
        if (m_active) begin
            off = cyc - m_gcyc;
            case (off)
                0: begin
                    e_busy = 1'b1;
                    e_en   = m_ok;
                    e_we   = m_ok && m_we;
                end
                1: begin
                    e_busy = 1'b1;
                    check_val("dout_resp", bus.dout, m_rdata);
                end
                default: begin
                    e_ack[m_g] = m_ok;
                    e_err[m_g] = !m_ok;
                    check_val("dout_ack", bus.dout, m_rdata);
                end
            endcase
        end
        check_val("busy", bus.busy, e_busy);
        check_val("cfg_en", bus.cfg_en, e_en);
        check_val("cfg_we", bus.cfg_we, e_we);
        check_val("ack", bus.ack, e_ack);
        check_val("err", bus.err, e_err);
        check_val("cfg_addr", bus.cfg_addr, m_cfg_addr);
        check_val("cfg_din", bus.cfg_din, m_cfg_din);
    endtask

    task automatic requesters();
        for (int k = 0; k < NREQ; k++) begin
            if (waiting[k] && (bus.ack[k] || bus.err[k])) begin
                waiting[k] = 1'b0;
                bus.req[k] = 1'b0;
            end else if (auto_mode && waiting[k] && m_active && m_g == k &&
                         (cyc - m_gcyc) <= 1 && $urandom_range(0, 3) == 0) begin
                // Granted requester lets go early and scrambles its inputs.
                bus.req[k]               = 1'b0;
                bus.req_addr[k*16 +: 16] = 16'($urandom);
                bus.req_din[k*DW +: DW]  = $urandom;
            end else if (auto_mode && !waiting[k] && $urandom_range(0, 2) == 0) begin
                issue(k, gen_addr(), ($urandom_range(0, 2) == 0), $urandom);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        model_and_check();
        requesters();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bus.req      = '0;
        bus.req_addr = '0;
        bus.req_we   = '0;
        bus.req_din  = '0;
        for (int k = 0; k < NREQ; k++) waiting[k] = 1'b0;
        rst = 1'b0;
        #2;
        do_reset();

        // Single read, legal write, then the three illegal accesses.
        issue(0, 16'h0004, 1'b0, '0);
        run(4);
        issue(1, 16'h0108, 1'b1, 32'h5);
        run(4);
        issue(0, 16'h0008, 1'b0, '0);
        run(4);
        issue(1, 16'h0000, 1'b1, 32'h1234);
        run(4);
        issue(0, 16'h0203, 1'b0, '0);
        run(4);

        // Contention: both requesters reissue as soon as they complete.
        issue(0, 16'h0000, 1'b0, '0);
        issue(1, 16'h0100, 1'b0, '0);
        for (int i = 0; i < 12; i++) begin
            step();
            for (int k = 0; k < NREQ; k++)
                if (!waiting[k]) issue(k, 16'(k * 16'h0104), 1'b0, '0);
        end
        run(8);

        // Reset during the ACCESS cycle of a write; both requesters stay pending.
        issue(1, 16'h0108, 1'b1, 32'hAB);
        issue(0, 16'h0108, 1'b1, 32'hCD);
        step();
        do_reset();
        run(8);

        auto_mode = 1'b1;
        run(3000);
        auto_mode = 1'b0;
        run(12);
        for (int k = 0; k < NREQ; k++) check_val("drained", waiting[k], 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
